ram_slow: RTL and testbench
===========================

Name: ram_slow

Overview:
- Word-addressed 32-bit backing memory with a fixed multi-cycle access latency.
- Serves as the main-memory model behind the 4-way cache.
- Has no explicit request strobe: a new request starts whenever the {data, addr, wr} tuple differs from the last accepted request.
- Completion is signalled by the response level returning high.

Parameters:
- DEPTH, 1024, number of 32-bit words stored.
- ADDR_BITS, 10, low address bits used to index the memory; DEPTH = 2^ADDR_BITS.
- LATENCY, 4, clock cycles from request acceptance to completion; legal range 1..15.

Ports:
- clk  input  1  single clock; all logic updates on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- data  input  32  write data.
- addr  input  32  word address; only addr[ADDR_BITS-1:0] is used.
- wr  input  1  1 = write, 0 = read.
- response  output  1  1 = idle or last request complete; 0 = request in progress.
- out  output  32  read data from the last completed read.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - response=1, out=0.
  - Latched request registers (data_q, addr_q, wr_q) = 0.
  - Busy flag and latency counter cleared.
  - Memory contents are not cleared by reset; the array initialises to all zeros at time 0.
- Reset mid-operation: the in-flight request is abandoned with no memory write and no out update; response=1 on the next cycle.
- Idle (response=1): at each rising edge, compare {data, addr, wr} with {data_q, addr_q, wr_q}.
  - Equal: nothing happens.
  - Different: latch the inputs into the _q registers, set response=0, load counter=LATENCY-1. This is the accept edge, T.
- Busy (response=0):
  - Inputs are ignored.
  - Counter decrements each edge.
  - At edge T+LATENCY the operation completes:
    - Write: mem[addr_q[ADDR_BITS-1:0]] <= data_q; out unchanged.
    - Read: out <= mem[addr_q[ADDR_BITS-1:0]].
    - response <= 1.
  - response is therefore low for exactly LATENCY cycles after T.
- Back-to-back: on the edge after completion, if the inputs already differ from the latched tuple, a new request is accepted on that edge. Minimum request spacing is LATENCY+1 cycles.
- Inputs changed during busy and then restored before completion generate no extra request. Comparison is only against the latched tuple.
- Re-issuing an identical request (same data, addr, wr) after completion does not restart an access. The requester must change some field.
  - Consequence: a read of addr 0 with data 0 right after reset is not executed; out stays 0, which matches zero-initialised memory.
- A read changing only the data field while wr=0 is a new request and re-reads memory.
- Address wrap: upper bits addr[31:ADDR_BITS] are ignored, so addresses alias modulo DEPTH.
- out holds its value between reads and across writes, including writes to the last-read address. A subsequent read is required to see new data.
- Read-after-write to the same address returns the written data, because the write completes before the read is accepted.
- No X propagation: out is always a defined value after reset.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles with inputs 0, release, wait 10 cycles -> response stays 1, out=0.
- Write/read latency: write data=0xDEADBEEF, addr=5, wr=1.
  - response goes 0 the cycle after the accept edge and stays 0 for exactly 4 cycles, then returns to 1.
  - Then read addr=5, wr=0 -> after 4 low cycles, out=0xDEADBEEF and response=1.
- Aliasing: write 0x12345678 to addr=3, then read addr=3+1024 -> out=0x12345678. A read of addr=4 returns 0.
- Busy-input masking: start a read of addr=5, then change addr to 9 on the next cycle while busy.
  - The first completion returns mem[5].
  - Next edge accepts addr=9, which completes 4 cycles later with mem[9].
- Identical re-issue: after a completed read of addr=5, hold the inputs constant for 20 cycles -> response remains 1, no further low pulse, out unchanged.
- Reset mid-operation: assert rst_n=0 two cycles into a write of 0xAAAA5555 to addr=7, release, then read addr=7 -> out=0 (write discarded) and response=1 immediately after reset.

Source files
------------

// File: rtl/ram_slow.sv
// Word-addressed 32-bit backing memory with a fixed multi-cycle access latency.
// A request starts whenever {data, addr, wr} differs from the last accepted tuple.
module ram_slow #(
  parameter int DEPTH     = 1024,
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data,
  input  logic [31:0] addr,
  input  logic        wr,
  output logic        response,
  output logic [31:0] out
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t state, state_d;

  logic [31:0] data_q;
  logic [31:0] addr_q;
  logic        wr_q;
  logic [3:0]  cnt;
  logic [31:0] out_q;
  logic        accept;
  logic        complete;

  // NOTE: the array is preloaded once and never touched by reset; clearing it
  // would need a multi-cycle sweep and would prevent block-RAM mapping.
  logic [31:0] mem [DEPTH] = '{default: '0};

  wire [ADDR_BITS-1:0] idx = addr_q[ADDR_BITS-1:0];

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state;
    accept   = 1'b0;
    complete = 1'b0;
    case (state)
      ST_IDLE: begin
        if ({data, addr, wr} != {data_q, addr_q, wr_q}) begin
          accept  = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt == 4'd0) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      data_q <= '0;
      addr_q <= '0;
      wr_q   <= 1'b0;
      cnt    <= '0;
      out_q  <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        data_q <= data;
        addr_q <= addr;
        wr_q   <= wr;
        cnt    <= 4'(LATENCY - 1);
      end else if (state == ST_BUSY && !complete) begin
        cnt <= cnt - 4'd1;
      end
      if (complete && !wr_q) out_q <= mem[idx];
    end
  end

  // Reset during an access abandons the pending write.
  always_ff @(posedge clk) begin
    if (rst_n && complete && wr_q) mem[idx] <= data_q;
  end

  assign response = (state == ST_IDLE);
  assign out      = out_q;

endmodule

// File: tb/tb_ram_slow.sv
// Directed bench for ram_slow: latency, aliasing, busy masking, re-issue, mid-op reset.
module tb_ram_slow;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data;
  logic [31:0] addr;
  logic        wr;
  logic        response;
  logic [31:0] out;

  int total = 0;
  int bad   = 0;

  ram_slow #(.DEPTH(1024), .ADDR_BITS(10), .LATENCY(4)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .addr(addr), .wr(wr),
    .response(response), .out(out)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request and count low-response cycles until it completes (bounded).
  task automatic do_req(input logic [31:0] d, input logic [31:0] a, input logic w,
                        output int low);
    data = d;
    addr = a;
    wr   = w;
    low  = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (response === 1'b0) low++;
      else break;
    end
  endtask

  initial begin
    int low;
    rst_n = 1'b0;
    data  = '0;
    addr  = '0;
    wr    = 1'b0;

    // Reset then idle
    tick(2);
    check("rst_response", 32'(response), 32'd1);
    check("rst_out", out, 32'h0);
    rst_n = 1'b1;
    low = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (response !== 1'b1) low++;
    end
    check("idle_low_cycles", 32'(low), 32'd0);
    check("idle_out", out, 32'h0);

    // Write/read latency
    do_req(32'hDEADBEEF, 32'd5, 1'b1, low);
    check("wr5_low_cycles", 32'(low), 32'd4);
    check("wr5_out_unchanged", out, 32'h0);
    do_req(32'h0, 32'd5, 1'b0, low);
    check("rd5_low_cycles", 32'(low), 32'd4);
    check("rd5_out", out, 32'hDEADBEEF);
    check("rd5_response", 32'(response), 32'd1);

    // Aliasing; write leaves out untouched
    do_req(32'h12345678, 32'd3, 1'b1, low);
    check("wr3_out_held", out, 32'hDEADBEEF);
    do_req(32'h0, 32'd3 + 32'd1024, 1'b0, low);
    check("rd1027_alias", out, 32'h12345678);
    do_req(32'h0, 32'd4, 1'b0, low);
    check("rd4_zero", out, 32'h0);

    // Data-only change on a read is a new request
    do_req(32'h1, 32'd3, 1'b0, low);
    do_req(32'h2, 32'd3, 1'b0, low);
    check("rd3_data_change_low", 32'(low), 32'd4);
    check("rd3_data_change_out", out, 32'h12345678);

    // Busy-input masking
    do_req(32'h0BADF00D, 32'd9, 1'b1, low);
    data = 32'h0;
    addr = 32'd5;
    wr   = 1'b0;
    tick();
    check("mask_accept_low", 32'(response), 32'd0);
    addr = 32'd9;
    tick(3);
    check("mask_still_busy", 32'(response), 32'd0);
    tick();
    check("mask_first_done", 32'(response), 32'd1);
    check("mask_first_out", out, 32'hDEADBEEF);
    tick();
    check("mask_second_accept", 32'(response), 32'd0);
    low = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (response === 1'b0) low++;
      else break;
    end
    check("mask_second_low", 32'(low), 32'd4);
    check("mask_second_out", out, 32'h0BADF00D);

    // Identical re-issue after a completed read of addr 5
    do_req(32'h0, 32'd5, 1'b0, low);
    check("reissue_first_out", out, 32'hDEADBEEF);
    low = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (response !== 1'b1) low++;
    end
    check("reissue_low_cycles", 32'(low), 32'd0);
    check("reissue_out_held", out, 32'hDEADBEEF);

    // Reset mid-operation discards the write
    data = 32'hAAAA5555;
    addr = 32'd7;
    wr   = 1'b1;
    tick(2);
    check("midrst_busy", 32'(response), 32'd0);
    rst_n = 1'b0;
    data  = 32'h0;
    wr    = 1'b0;
    tick();
    check("midrst_response", 32'(response), 32'd1);
    check("midrst_out", out, 32'h0);
    rst_n = 1'b1;
    do_req(32'h0, 32'd7, 1'b0, low);
    check("midrst_rd7_low", 32'(low), 32'd4);
    check("midrst_rd7_out", out, 32'h0);
    check("midrst_rd7_response", 32'(response), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
